overcurrent_monitor: RTL
========================

# overcurrent_monitor

Multi-channel overcurrent protection block: each of NUM_CH channels compares its ADC current sample against a threshold, debounces persistent overcurrent, then asserts a trip. A tripped channel holds off for a cooldown period and auto-retries a bounded number of times before locking out until software clears it. It sits between the ADC sample demux and the gate-driver enable logic, and generalises the single-channel current limiter.

## Interface
- NUM_CH, 4: number of monitored channels (1..16)
- DATA_W, 12: ADC sample width
- CURRENT_MAX, 12'd2500: trip threshold (≈2 V); strictly-greater-than compare
- TIME_LIMIT, 1000000: consecutive over-threshold valid samples required to trip (≥1)
- RETRY_DELAY, 5000000: cooldown length in clk cycles after a trip (≥1)
- MAX_RETRIES, 3: auto-retries allowed before lockout (0 = lock out on first trip)
- HYST, 12'd100: release margin; only used with OC_HYSTERESIS_EN
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- sample_valid  in  1  one-cycle strobe; current_in is valid for all channels
- current_in  in  NUM_CH*DATA_W  packed samples, channel i at [i*DATA_W +: DATA_W]
- fault_clr  in  NUM_CH  per-channel clear, level-sampled each cycle
- trip  out  NUM_CH  registered; 1 = channel driver must be disabled
- lockout  out  NUM_CH  registered; 1 = channel exhausted retries
- any_trip  out  1  combinational OR of trip (no added latency)

## Operation
- Per-channel FSM states: NORMAL, PENDING, TRIPPED, LOCKOUT.
- NORMAL: on valid sample > CURRENT_MAX, debounce counter := 1; go to PENDING, or directly to TRIPPED if TIME_LIMIT == 1.
- PENDING: each valid sample > CURRENT_MAX increments the counter. When it reaches TIME_LIMIT, go to TRIPPED. A valid sample ≤ CURRENT_MAX clears the counter and returns to NORMAL. Cycles without sample_valid hold state.
- TRIPPED: trip=1. Cooldown counter counts clk cycles (not samples) up to RETRY_DELAY. On expiry:
  - if retry_cnt < MAX_RETRIES: retry_cnt++, go to NORMAL
  - else go to LOCKOUT
- LOCKOUT: trip=1, lockout=1. Held until fault_clr.
- fault_clr[i] has highest priority in every state: the channel goes to NORMAL and clears the debounce counter, cooldown counter and retry_cnt. A sample arriving in the same cycle is ignored.
- retry_cnt is cleared only by fault_clr or reset; it is not cleared by time spent in NORMAL.
- Samples are ignored in TRIPPED and LOCKOUT.
- Counter widths: $clog2(limit+1); counters saturate and never wrap.
- Channels are fully independent; simultaneous trips on all channels are legal.

## Timing
- Reset values: all FSMs in NORMAL, all counters 0, trip=0, lockout=0, any_trip=0.
- trip rises the clock edge after the TIME_LIMIT-th consecutive qualifying sample is presented.
- trip stays high for exactly RETRY_DELAY cycles in TRIPPED, then falls on the next edge (retry) or stays high with lockout rising on that edge.
- fault_clr asserted in cycle N: trip and lockout are low after edge N.
- Reset asserted mid-trip clears all outputs asynchronously.

## Configuration
- OC_HYSTERESIS_EN defined: in PENDING, a valid sample resets the debounce counter only if it is ≤ CURRENT_MAX − HYST. Samples between the two thresholds hold the counter and state.
- OC_HYSTERESIS_EN undefined: any sample ≤ CURRENT_MAX resets the counter; HYST is unused.

## Structure
- Package oc_pkg: state enum oc_state_t {NORMAL, PENDING, TRIPPED, LOCKOUT} and the default threshold constant.
- Sub-module oc_channel: one FSM with its counters, instantiated NUM_CH times by generate.
- Top level: slices current_in and forms any_trip.

## Test plan
- TIME_LIMIT=4, 4 consecutive valid samples of 2600 on ch0 -> trip[0]=1 one edge after the 4th sample; other channels stay 0; any_trip=1.
- 3 samples of 2600, then 2500, then 4 of 2600 -> no trip until after the last 4; without OC_HYSTERESIS_EN, 2500 resets the count.
- OC_HYSTERESIS_EN, HYST=100: pattern 2600, 2600, 2450, 2600, 2600 with TIME_LIMIT=4 -> trip after the 5th sample, because 2450 holds the count. Pattern with 2400 in place of 2450 -> no trip.
- RETRY_DELAY=10, MAX_RETRIES=2, sustained 3000 -> trip pulses high for 10 cycles at each retry; the 3rd trip leaves trip=1 and lockout=1 permanently; fault_clr[0] -> both low after the next edge.
- fault_clr on ch1 asserted in the same cycle as its 4th over-threshold sample -> no trip, counter 0.
- rst_n pulled low while two channels are TRIPPED -> trip, lockout and any_trip are 0 immediately; normal debounce resumes after release.

Source files
------------

// File: rtl/oc_pkg.sv
// rtl/oc_pkg.sv - shared types and constants for the overcurrent monitor
// Contents:
//   oc_state_t             per-channel protection state
//   OC_CURRENT_MAX_DEFAULT default trip threshold in ADC counts
//   HYST_EN                1 when built with OC_HYSTERESIS_EN defined, else 0
//   cnt_w()                width of a counter that must hold 0..limit (at least 1 bit)
package oc_pkg;

  typedef enum logic [1:0] {
    NORMAL  = 2'd0,
    PENDING = 2'd1,
    TRIPPED = 2'd2,
    LOCKOUT = 2'd3
  } oc_state_t;

  localparam int OC_CURRENT_MAX_DEFAULT = 2500;

`ifdef OC_HYSTERESIS_EN
  localparam bit HYST_EN = 1'b1;
`else
  localparam bit HYST_EN = 1'b0;
`endif

  function automatic int cnt_w(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/oc_channel.sv
// rtl/oc_channel.sv - one overcurrent channel: debounce, trip, cooldown, retry, lockout
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   sample_valid   strobe qualifying sample
//   sample         ADC current sample for this channel
//   fault_clr      level clear; overrides everything, returns the channel to NORMAL
//   trip           registered; channel driver must be disabled
//   lockout        registered; retries exhausted, waiting for fault_clr
// Macro OC_HYSTERESIS_EN (via oc_pkg::HYST_EN) enables the release band below CURRENT_MAX.
module oc_channel
  import oc_pkg::*;
#(
  parameter int DATA_W      = 12,
  parameter int CURRENT_MAX = OC_CURRENT_MAX_DEFAULT,
  parameter int TIME_LIMIT  = 1000000,
  parameter int RETRY_DELAY = 5000000,
  parameter int MAX_RETRIES = 3,
  parameter int HYST        = 100
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample,
  input  logic              fault_clr,
  output logic              trip,
  output logic              lockout
);

  localparam int DW  = cnt_w(TIME_LIMIT);
  localparam int CW  = cnt_w(RETRY_DELAY);
  localparam int RW  = cnt_w(MAX_RETRIES);
  // Without hysteresis the release level equals the trip level, so every
  // non-over sample also counts as a release sample.
  localparam int REL = HYST_EN ? (CURRENT_MAX - HYST) : CURRENT_MAX;

  localparam logic [DW-1:0] DEB_LAST  = DW'(TIME_LIMIT - 1);
  localparam logic [CW-1:0] COOL_LAST = CW'(RETRY_DELAY - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRIES);

  oc_state_t     state;
  logic [DW-1:0] deb_cnt;
  logic [CW-1:0] cool_cnt;
  logic [RW-1:0] retry_cnt;

  int   samp;
  logic over;
  logic release_ok;

  assign samp       = int'(sample);
  assign over       = (samp > CURRENT_MAX);
  assign release_ok = (samp <= REL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= NORMAL;
      deb_cnt   <= '0;
      cool_cnt  <= '0;
      retry_cnt <= '0;
      trip      <= 1'b0;
      lockout   <= 1'b0;
    end else if (fault_clr) begin
      state     <= NORMAL;
      deb_cnt   <= '0;
      cool_cnt  <= '0;
      retry_cnt <= '0;
      trip      <= 1'b0;
      lockout   <= 1'b0;
    end else begin
      case (state)
        NORMAL, PENDING: begin
          if (sample_valid) begin
            if (over) begin
              // deb_cnt never exceeds TIME_LIMIT-1, so this sample is the last one needed.
              if (deb_cnt >= DEB_LAST) begin
                state    <= TRIPPED;
                deb_cnt  <= '0;
                cool_cnt <= '0;
                trip     <= 1'b1;
              end else begin
                deb_cnt <= deb_cnt + DW'(1);
                state   <= PENDING;
              end
            end else if (release_ok) begin
              deb_cnt <= '0;
              state   <= NORMAL;
            end
            // Samples inside the hysteresis band hold both count and state.
          end
        end
        TRIPPED: begin
          // Trip was raised on entry with cool_cnt = 0, so it stays high for
          // exactly RETRY_DELAY cycles before this branch resolves.
          if (cool_cnt >= COOL_LAST) begin
            cool_cnt <= '0;
            if (retry_cnt < RETRY_MAX) begin
              retry_cnt <= retry_cnt + RW'(1);
              state     <= NORMAL;
              trip      <= 1'b0;
            end else begin
              state   <= LOCKOUT;
              lockout <= 1'b1;
            end
          end else begin
            cool_cnt <= cool_cnt + CW'(1);
          end
        end
        LOCKOUT: begin
          trip    <= 1'b1;
          lockout <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/overcurrent_monitor.sv
// rtl/overcurrent_monitor.sv - multi-channel overcurrent protection top level
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   sample_valid   one-cycle strobe; current_in valid for all channels
//   current_in     packed samples, channel i at [i*DATA_W +: DATA_W]
//   fault_clr      per-channel clear, level-sampled
//   trip           per-channel registered trip
//   lockout        per-channel registered lockout
//   any_trip       combinational OR of trip
// Macro OC_HYSTERESIS_EN enables the release hysteresis band of HYST counts.
module overcurrent_monitor
  import oc_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int DATA_W      = 12,
  parameter int CURRENT_MAX = OC_CURRENT_MAX_DEFAULT,
  parameter int TIME_LIMIT  = 1000000,
  parameter int RETRY_DELAY = 5000000,
  parameter int MAX_RETRIES = 3,
  parameter int HYST        = 100
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     sample_valid,
  input  logic [NUM_CH*DATA_W-1:0] current_in,
  input  logic [NUM_CH-1:0]        fault_clr,
  output logic [NUM_CH-1:0]        trip,
  output logic [NUM_CH-1:0]        lockout,
  output logic                     any_trip
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    oc_channel #(
      .DATA_W      (DATA_W),
      .CURRENT_MAX (CURRENT_MAX),
      .TIME_LIMIT  (TIME_LIMIT),
      .RETRY_DELAY (RETRY_DELAY),
      .MAX_RETRIES (MAX_RETRIES),
      .HYST        (HYST)
    ) u_ch (
      .clk          (clk),
      .rst_n        (rst_n),
      .sample_valid (sample_valid),
      .sample       (current_in[i*DATA_W +: DATA_W]),
      .fault_clr    (fault_clr[i]),
      .trip         (trip[i]),
      .lockout      (lockout[i])
    );
  end

  assign any_trip = |trip;

endmodule
